// File: rtl/tnn_pkg.sv
// Shared constants and FSM state type for the ternary neuron sequencer.
// TNN_IN_W  : input vector width handled by the shared popcount unit
// TNN_CNT_W : popcount result width (0..22 fits in 5 bits)
// TNN_THR_W : signed threshold / difference width
package tnn_pkg;

  localparam int TNN_IN_W  = 22;
  localparam int TNN_CNT_W = 5;
  localparam int TNN_THR_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POS  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } tnn_seq_state_t;

endpackage

// File: rtl/popcount22_exact.sv
// Combinational exact popcount of a 22-bit vector.
// Port shape matches the approximate popcount library cells so either can be
// dropped into the sequencer.
//   bits_i : vector to count
//   cnt_o  : number of set bits in bits_i
module popcount22_exact
  import tnn_pkg::*;
(
  input  logic [TNN_IN_W-1:0]  bits_i,
  output logic [TNN_CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < TNN_IN_W; i++) begin
      cnt_o = cnt_o + TNN_CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/ternary_neuron_sequencer.sv
// Time-multiplexed ternary neuron layer. Each accepted vector is evaluated one
// neuron at a time: a POS pass counts inputs under the +1 mask, a NEG pass
// counts inputs under the -1 mask, and the neuron fires when the signed
// difference reaches its threshold. One shared popcount unit serves all passes.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input vector handshake, in_data is the vector
//   cfg_we/cfg_addr     : weight/threshold write (accepted only while idle)
//   cfg_pos/cfg_neg     : +1 / -1 weight masks, cfg_thr signed threshold
//   out_valid/out_ready : result handshake, out_bits[k] is neuron k
module ternary_neuron_sequencer
  import tnn_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IN_W      = TNN_IN_W,
  parameter int CNT_W     = TNN_CNT_W,
  parameter int THR_W     = TNN_THR_W,
  localparam int AW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [IN_W-1:0]         cfg_pos,
  input  logic [IN_W-1:0]         cfg_neg,
  input  logic signed [THR_W-1:0] cfg_thr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_NEURONS-1:0]    out_bits
);

  tnn_seq_state_t state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [IN_W-1:0]      vec_q, vec_d;
  logic [CNT_W-1:0]     pos_cnt_q, pos_cnt_d;
  logic [N_NEURONS-1:0] out_bits_q, out_bits_d;
  logic                 out_valid_q, out_valid_d;

  logic [IN_W-1:0]         pos_mask_q [N_NEURONS];
  logic [IN_W-1:0]         neg_mask_q [N_NEURONS];
  logic signed [THR_W-1:0] thr_q      [N_NEURONS];

  logic [IN_W-1:0]  pc_in;
  logic [CNT_W-1:0] pc_cnt;
  logic             cfg_hit;

  // Signed compare of (pos - neg) against the threshold. Both counts are
  // zero-extended first, so the difference spans -22..+22 without overflow.
  function automatic logic neuron_fires(input logic [CNT_W-1:0] p,
                                        input logic [CNT_W-1:0] n,
                                        input logic signed [THR_W-1:0] thr);
    logic signed [THR_W-1:0] diff;
    diff = signed'(THR_W'(p)) - signed'(THR_W'(n));
    return (diff >= thr);
  endfunction

  popcount22_exact u_popcount (
    .bits_i (pc_in),
    .cnt_o  (pc_cnt)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;

  // Writes land only while idle so an evaluation never sees a half-updated
  // neuron; out-of-range addresses are dropped.
  assign cfg_hit = cfg_we && (state_q == S_IDLE) &&
                   ({1'b0, cfg_addr} < (AW+1)'(N_NEURONS));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    pos_cnt_d   = pos_cnt_q;
    out_bits_d  = out_bits_q;
    pc_in       = vec_q & pos_mask_q[idx_q];
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          vec_d      = in_data;
          idx_d      = '0;
          out_bits_d = '0;
          state_d    = S_POS;
        end
      end
      S_POS: begin
        pos_cnt_d = pc_cnt;
        state_d   = S_NEG;
      end
      S_NEG: begin
        pc_in             = vec_q & neg_mask_q[idx_q];
        out_bits_d[idx_q] = neuron_fires(pos_cnt_q, pc_cnt, thr_q[idx_q]);
        if (idx_q == AW'(N_NEURONS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_POS;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      vec_q       <= '0;
      pos_cnt_q   <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      pos_cnt_q   <= pos_cnt_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_NEURONS; k++) begin
      if (rst) begin
        pos_mask_q[k] <= '0;
        neg_mask_q[k] <= '0;
        thr_q[k]      <= '0;
      end else if (cfg_hit && (cfg_addr == AW'(k))) begin
        pos_mask_q[k] <= cfg_pos;
        neg_mask_q[k] <= cfg_neg;
        thr_q[k]      <= cfg_thr;
      end
    end
  end

endmodule

// File: tb/tb_ternary_neuron_sequencer.sv
// Directed bench for ternary_neuron_sequencer (N_NEURONS=4).
module tb_ternary_neuron_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_data;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [21:0] cfg_pos;
  logic [21:0] cfg_neg;
  logic [5:0]  cfg_thr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_bits;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  ternary_neuron_sequencer #(.N_NEURONS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_pos   (cfg_pos),
    .cfg_neg   (cfg_neg),
    .cfg_thr   (cfg_thr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [21:0] p,
                           input logic [21:0] n, input logic [5:0] t);
    cfg_addr = a; cfg_pos = p; cfg_neg = n; cfg_thr = t;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  // Presents a vector in IDLE; cycle 0 ends at the accept edge. Optionally
  // pulses cfg_we during cycle cfg_cyc. Returns the cycle where out_valid is
  // first seen (bounded at 40).
  task automatic run_vec(input logic [21:0] d, input int cfg_cyc, output int c);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    c = 1;
    while (!out_valid && c < 40) begin
      cfg_we = (c == cfg_cyc);
      step();
      cfg_we = 1'b0;
      c++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_pos = '0; cfg_neg = '0; cfg_thr = '0; out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);

    // unconfigured layer: every neuron fires
    run_vec(22'h3FFFFF, -1, lat);
    chk("t1_latency", lat, 9);
    chk("t1_bits", out_bits, 4'b1111);
    step();
    chk("t1_back_idle", in_ready, 1);
    chk("t1_valid_low", out_valid, 0);

    // neuron 0: pos 8, neg 1, diff 7
    cfg_write(2'd0, 22'h0000FF, 22'h00FF00, 6'd1);
    run_vec(22'h0001FF, -1, lat);
    chk("t2_latency", lat, 9);
    chk("t2_thr1_bits", out_bits, 4'b1111);
    step();
    cfg_write(2'd0, 22'h0000FF, 22'h00FF00, 6'd8);
    run_vec(22'h0001FF, -1, lat);
    chk("t2_thr8_bits", out_bits, 4'b1110);
    step();

    // neuron 2 negative thresholds; neuron 0 sees diff 0 < 8
    cfg_write(2'd2, 22'h000000, 22'h3FFFFF, 6'h2A); // -22
    run_vec(22'h3FFFFF, -1, lat);
    chk("t3_thrm22_bits", out_bits, 4'b1110);
    step();
    cfg_write(2'd2, 22'h000000, 22'h3FFFFF, 6'h2B); // -21
    run_vec(22'h3FFFFF, -1, lat);
    chk("t3_thrm21_bits", out_bits, 4'b1010);
    step();

    // backpressure held for 5 cycles in DONE
    out_ready = 1'b0;
    run_vec(22'h3FFFFF, -1, lat);
    chk("t4_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_bits", out_bits, 4'b1010);
      chk("t4_hold_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 22'h000000;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t4_still_done", out_valid, 1);
    step();
    chk("t4_release_idle", in_ready, 1);
    chk("t4_release_valid", out_valid, 0);

    // config write mid-evaluation is ignored
    cfg_addr = 2'd3; cfg_pos = '0; cfg_neg = '0; cfg_thr = 6'd31;
    run_vec(22'h3FFFFF, 3, lat);
    chk("t5_latency", lat, 9);
    chk("t5_old_thr_bits", out_bits, 4'b1010);
    step();
    run_vec(22'h3FFFFF, -1, lat);
    chk("t5_stored_unchanged", out_bits, 4'b1010);
    step();

    // reset at cycle 4 aborts and clears config
    in_data = 22'h3FFFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid_low", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_bits_cleared", out_bits, 0);
    run_vec(22'h3FFFFF, -1, lat);
    chk("t6_latency", lat, 9);
    chk("t6_cfg_cleared", out_bits, 4'b1111);
    step();

    // write and accept in the same idle cycle: new weights are used
    cfg_addr = 2'd1; cfg_pos = 22'h3FFFFF; cfg_neg = '0; cfg_thr = 6'd23;
    cfg_we = 1'b1;
    run_vec(22'h3FFFFF, -1, lat);
    chk("t7_same_cycle_bits", out_bits, 4'b1101);
    step();
    run_vec(22'h0FFFFF, -1, lat); // diff 20 vs 23
    chk("t7_followup_bits", out_bits, 4'b1101);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
